// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one asynchronous RAM between two requesters.
// Latency: request seen in IDLE at cycle N is acked at cycle N+3; 4 cycles per access.
// Backpressure: requests are level-held until ack; the loser simply waits in IDLE.
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_drive,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  state_t state;
  logic   last;   // requester served most recently; the other one wins a tie
  logic   wr_q;   // access type latched at grant
  logic   pick;   // requester that would be granted this cycle

  // Arbitration: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    pick = (req0 && req1) ? ~last : req1;
  end

  // Access sequencer; every output is a register updated with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      wr_q      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
      grant     <= 1'b0;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_drive <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            // Latch the winner's request; ram_addr/ram_dout double as the
            // held copies, so later changes on the request side are ignored.
            state     <= SETUP;
            busy      <= 1'b1;
            grant     <= pick;
            last      <= pick;
            wr_q      <= pick ? wr1 : wr0;
            ram_addr  <= pick ? addr1 : addr0;
            ram_dout  <= pick ? wdata1 : wdata0;
            ram_drive <= pick ? wr1 : wr0;
            ram_cs    <= 1'b1;
          end
        end
        SETUP: begin
          // Address and data have had a full cycle to settle; assert the strobe.
          state <= ACCESS;
          if (wr_q) ram_we <= 1'b1;
          else      ram_oe <= 1'b1;
        end
        ACCESS: begin
          // Release the RAM and capture read data while oe is still applied.
          state     <= RECOVER;
          ram_cs    <= 1'b0;
          ram_we    <= 1'b0;
          ram_oe    <= 1'b0;
          ram_drive <= 1'b0;
          if (!wr_q) rd_data <= ram_din;
          ack0 <= ~grant;
          ack1 <= grant;
        end
        RECOVER: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32x4 RAM attached.
// Cycle 0 is the IDLE cycle in which a request is first presented.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, wr0, req1, wr1;
  logic [4:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;
  logic       ack0, ack1, busy, grant;
  logic [3:0] rd_data, ram_dout;
  logic [4:0] ram_addr;
  logic       ram_drive, ram_cs, ram_we, ram_oe;
  logic [3:0] ram_din;

  logic [3:0] mem [32];
  logic       mem_init;
  logic [6:0] st;

  int checks = 0;
  int passed = 0;

  ram_arbiter #(.ADDR_W(5), .DATA_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rd_data(rd_data), .busy(busy), .grant(grant),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_drive(ram_drive),
    .ram_din(ram_din), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  always #5 clk = ~clk;

  // RAM model: writes while cs&we, reads combinationally while cs&oe.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= i[3:0];
    end else if (ram_cs && ram_we) begin
      mem[ram_addr] <= ram_dout;
    end
  end
  assign ram_din = ram_drive ? ram_dout : ((ram_cs && ram_oe) ? mem[ram_addr] : 4'h0);

  // {cs, we, oe, drive, busy, ack0, ack1}
  assign st = {ram_cs, ram_we, ram_oe, ram_drive, busy, ack0, ack1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_init = 1'b1;
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    #12;
    checks++; if (st !== 7'b0) $display("FAIL reset_strobes: got %b expected %b", st, 7'b0); else passed++;
    checks++; if (rd_data !== 4'h0) $display("FAIL reset_rd_data: got %h expected 0", rd_data); else passed++;
    checks++; if (grant !== 1'b0) $display("FAIL reset_grant: got %b expected 0", grant); else passed++;
    checks++; if (ram_addr !== 5'h0) $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); else passed++;
    checks++; if (ram_dout !== 4'h0) $display("FAIL reset_ram_dout: got %h expected 0", ram_dout); else passed++;
    @(posedge clk); #1;
    reset = 1'b0; mem_init = 1'b0;
  endtask

  task automatic test_write();
    req0 = 1; wr0 = 1; addr0 = 5'h0A; wdata0 = 4'h6;
    checks++; if (st !== 7'b0) $display("FAIL wr_c0: got %b expected %b", st, 7'b0); else passed++;
    tick();
    checks++; if (st !== 7'b1001100) $display("FAIL wr_setup: got %b expected %b", st, 7'b1001100); else passed++;
    checks++; if ({ram_addr, ram_dout, grant} !== {5'h0A, 4'h6, 1'b0})
      $display("FAIL wr_setup_bus: got addr %h dout %h grant %b expected 0a 6 0", ram_addr, ram_dout, grant); else passed++;
    tick();
    checks++; if (st !== 7'b1101100) $display("FAIL wr_access: got %b expected %b", st, 7'b1101100); else passed++;
    tick();
    checks++; if (st !== 7'b0000110) $display("FAIL wr_recover: got %b expected %b", st, 7'b0000110); else passed++;
    req0 = 0;
    tick();
    checks++; if (st !== 7'b0) $display("FAIL wr_idle: got %b expected %b", st, 7'b0); else passed++;
    checks++; if (mem[5'h0A] !== 4'h6) $display("FAIL wr_mem: got %h expected 6", mem[5'h0A]); else passed++;
  endtask

  task automatic test_readback();
    req1 = 1; wr1 = 0; addr1 = 5'h0A;
    tick();
    checks++; if ({st, grant} !== 8'b10001001) $display("FAIL rd_setup: got %b expected %b", {st, grant}, 8'b10001001); else passed++;
    tick();
    checks++; if (st !== 7'b1010100) $display("FAIL rd_access: got %b expected %b", st, 7'b1010100); else passed++;
    tick();
    checks++; if (st !== 7'b0000101) $display("FAIL rd_recover: got %b expected %b", st, 7'b0000101); else passed++;
    checks++; if (rd_data !== 4'h6) $display("FAIL rd_data: got %h expected 6", rd_data); else passed++;
    req1 = 0;
    tick();
  endtask

  task automatic test_write_keeps_rd_data();
    req0 = 1; wr0 = 1; addr0 = 5'h05; wdata0 = 4'hC;
    tick(); tick(); tick();
    checks++; if (st !== 7'b0000110) $display("FAIL wr2_recover: got %b expected %b", st, 7'b0000110); else passed++;
    checks++; if (rd_data !== 4'h6) $display("FAIL wr2_rd_hold: got %h expected 6", rd_data); else passed++;
    req0 = 0;
    tick();
    checks++; if (mem[5'h05] !== 4'hC) $display("FAIL wr2_mem: got %h expected c", mem[5'h05]); else passed++;
  endtask

  task automatic test_tie();
    logic [7:0] a0, a1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a0 = '0; a1 = '0;
    req0 = 1; wr0 = 0; addr0 = 5'h0A;
    req1 = 1; wr1 = 0; addr1 = 5'h03;
    for (int c = 1; c < 8; c++) begin
      tick();
      a0[c] = ack0; a1[c] = ack1;
      if (ack0) req0 = 0;
      if (ack1) req1 = 0;
    end
    checks++; if (a0 !== 8'h08) $display("FAIL tie_ack0: got %b expected %b", a0, 8'h08); else passed++;
    checks++; if (a1 !== 8'h80) $display("FAIL tie_ack1: got %b expected %b", a1, 8'h80); else passed++;
    checks++; if (rd_data !== 4'h3) $display("FAIL tie_rd_data: got %h expected 3", rd_data); else passed++;
    tick();
  endtask

  task automatic test_contention();
    logic [15:0] a0, a1;
    logic        bad;
    a0 = '0; a1 = '0; bad = 0;
    req0 = 1; wr0 = 0; addr0 = 5'h0A;
    req1 = 1; wr1 = 0; addr1 = 5'h03;
    for (int c = 1; c < 16; c++) begin
      tick();
      a0[c] = ack0; a1[c] = ack1;
      if ((ram_we && ram_oe) || (ram_drive && ram_oe)) bad = 1;
    end
    req0 = 0; req1 = 0;
    checks++; if (a0 !== 16'h0808) $display("FAIL cont_ack0: got %h expected 0808", a0); else passed++;
    checks++; if (a1 !== 16'h8080) $display("FAIL cont_ack1: got %h expected 8080", a1); else passed++;
    checks++; if (bad !== 1'b0) $display("FAIL cont_strobe_overlap: got %b expected 0", bad); else passed++;
    tick();
    checks++; if (st !== 7'b0) $display("FAIL cont_idle: got %b expected %b", st, 7'b0); else passed++;
  endtask

  task automatic test_reset_in_access();
    logic [3:0] a0, a1;
    req0 = 1; wr0 = 1; addr0 = 5'h01; wdata0 = 4'h9;
    tick(); tick();
    checks++; if (st !== 7'b1101100) $display("FAIL rst_pre_access: got %b expected %b", st, 7'b1101100); else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (st !== 7'b0) $display("FAIL rst_async_drop: got %b expected %b", st, 7'b0); else passed++;
    req0 = 0;
    tick();
    reset = 1'b0;
    checks++; if (mem[5'h01] !== 4'h1) $display("FAIL rst_no_write: got %h expected 1", mem[5'h01]); else passed++;
    a0 = '0; a1 = '0;
    req0 = 1; wr0 = 0; addr0 = 5'h0A;
    req1 = 1; wr1 = 0; addr1 = 5'h03;
    for (int c = 1; c < 4; c++) begin
      tick();
      a0[c] = ack0; a1[c] = ack1;
    end
    req0 = 0; req1 = 0;
    checks++; if ({a0, a1} !== 8'h80) $display("FAIL rst_tie: got ack0 %b ack1 %b expected 1000 0000", a0, a1); else passed++;
    tick();
  endtask

  task automatic test_abandon();
    logic bad;
    bad = 0;
    req0 = 1; wr0 = 0; addr0 = 5'h03;
    tick();
    req0 = 0;
    tick(); tick();
    checks++; if (st !== 7'b0000110) $display("FAIL abandon_ack: got %b expected %b", st, 7'b0000110); else passed++;
    checks++; if (rd_data !== 4'h3) $display("FAIL abandon_rd_data: got %h expected 3", rd_data); else passed++;
    for (int c = 4; c < 9; c++) begin
      tick();
      if (st !== 7'b0) bad = 1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL abandon_idle: got %b expected 0", bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_write_keeps_rd_data();
    test_tie();
    test_contention();
    test_reset_in_access();
    test_abandon();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
